// File: rtl/safebox_pkg.sv
// Shared definitions for the safe box: FSM state encoding, default tick rate,
// and a width helper for the tick down-counter.
package safebox_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_ALARM    = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_t;

    // Same divider rate as the LED/buzzer alarm block, so both share one tick period.
    localparam int DEFAULT_TICK_DIV = 800000;

    function automatic int ticks_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/safe_alarm_sequencer_if.sv
// Attempt/control inputs and status outputs of the safe alarm sequencer.
// ALARM_ESCALATE_EN adds the escalated status line.
interface safe_alarm_sequencer_if;

    logic       attempt_valid;
    logic       attempt_ok;
    logic       lock_req;
    logic       admin_clear;
    logic       alarm;
    logic       unlocked;
    logic       locked_out;
    logic       reject;
    logic [3:0] fail_cnt;
    logic [1:0] state;
`ifdef ALARM_ESCALATE_EN
    logic       escalated;

    modport master (
        output attempt_valid, attempt_ok, lock_req, admin_clear,
        input  alarm, unlocked, locked_out, reject, fail_cnt, state, escalated
    );
    modport slave (
        input  attempt_valid, attempt_ok, lock_req, admin_clear,
        output alarm, unlocked, locked_out, reject, fail_cnt, state, escalated
    );
`else
    modport master (
        output attempt_valid, attempt_ok, lock_req, admin_clear,
        input  alarm, unlocked, locked_out, reject, fail_cnt, state
    );
    modport slave (
        input  attempt_valid, attempt_ok, lock_req, admin_clear,
        output alarm, unlocked, locked_out, reject, fail_cnt, state
    );
`endif

endinterface

// File: rtl/safe_tick_timer.sv
// Prescaler plus tick down-counter; a load restarts both, so a loaded value N
// expires exactly N*TICK_DIV cycles after the loading edge.
module safe_tick_timer #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expire
);

    localparam int PRESC_W = $clog2(TICK_DIV);

    logic [PRESC_W-1:0] r_presc;
    logic [CNT_W-1:0]   r_timer;
    logic               w_tick;

    assign w_tick   = (r_presc == PRESC_W'(TICK_DIV - 1));
    assign o_expire = w_tick && (r_timer == CNT_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_timer <= '0;
        end else if (i_load) begin
            r_presc <= '0;
            r_timer <= i_load_val;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
            if (w_tick && (r_timer != '0))
                r_timer <= r_timer - CNT_W'(1);
        end
    end

endmodule

// File: rtl/safe_alarm_sequencer.sv
// Security sequencer: counts failed attempts, drives a timed alarm, then a
// lockout, and auto-relocks the unlocked window. Optional: ALARM_ESCALATE_EN.
module safe_alarm_sequencer
    import safebox_pkg::*;
#(
    parameter int MAX_FAILS    = 3,
    parameter int TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int ALARM_TICKS  = 30,
    parameter int LOCK_TICKS   = 60,
    parameter int UNLOCK_TICKS = 100
) (
    input logic                  clk,
    input logic                  rst_n,
    safe_alarm_sequencer_if.slave bus
);

    localparam int         CNT_W = ticks_width(ALARM_TICKS, LOCK_TICKS, UNLOCK_TICKS);
    localparam logic [3:0] MAX_F = 4'(MAX_FAILS);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_fail_cnt;
    logic [3:0]       w_fail_next;
    logic [3:0]       w_fail_inc;
    logic             r_alarm;
    logic             r_unlocked;
    logic             r_locked_out;
    logic             r_reject;
    logic             w_reject;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_expire;
    logic             w_timeout_en;

`ifdef ALARM_ESCALATE_EN
    logic [1:0] r_trips;
    logic [1:0] w_trips_next;
    logic       r_escalated;

    // From the second trip on, ALARM is held until an admin clears it.
    assign w_timeout_en  = (r_trips < 2'd2);
    assign bus.escalated = r_escalated;
`else
    assign w_timeout_en  = 1'b1;
`endif

    assign w_fail_inc = (r_fail_cnt >= MAX_F) ? MAX_F : r_fail_cnt + 4'd1;

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        w_next      = r_state;
        w_fail_next = r_fail_cnt;
        w_reject    = 1'b0;
`ifdef ALARM_ESCALATE_EN
        w_trips_next = r_trips;
`endif
        if (bus.admin_clear) begin
            w_next      = ST_IDLE;
            w_fail_next = 4'd0;
`ifdef ALARM_ESCALATE_EN
            w_trips_next = 2'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.attempt_valid && bus.attempt_ok) begin
                        w_next      = ST_UNLOCKED;
                        w_fail_next = 4'd0;
`ifdef ALARM_ESCALATE_EN
                        w_trips_next = 2'd0;
`endif
                    end else if (bus.attempt_valid) begin
                        w_fail_next = w_fail_inc;
                        if (w_fail_inc == MAX_F) begin
                            w_next = ST_ALARM;
`ifdef ALARM_ESCALATE_EN
                            w_trips_next = (r_trips == 2'd3) ? 2'd3 : r_trips + 2'd1;
`endif
                        end
                    end
                end
                ST_UNLOCKED: begin
                    w_reject = bus.attempt_valid;
                    if (bus.lock_req || w_expire)
                        w_next = ST_IDLE;
                end
                ST_ALARM: begin
                    w_reject = bus.attempt_valid;
                    if (w_expire && w_timeout_en)
                        w_next = ST_LOCKOUT;
                end
                ST_LOCKOUT: begin
                    w_reject = bus.attempt_valid;
                    if (w_expire) begin
                        w_next      = ST_IDLE;
                        w_fail_next = 4'd0;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Every state entry (and every admin clear) restarts the timebase.
    assign w_load = bus.admin_clear || (w_next != r_state);

    always_comb begin
        case (w_next)
            ST_UNLOCKED: w_load_val = CNT_W'(UNLOCK_TICKS);
            ST_ALARM:    w_load_val = CNT_W'(ALARM_TICKS);
            ST_LOCKOUT:  w_load_val = CNT_W'(LOCK_TICKS);
            default:     w_load_val = '0;
        endcase
    end

    safe_tick_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_fail_cnt   <= 4'd0;
            r_alarm      <= 1'b0;
            r_unlocked   <= 1'b0;
            r_locked_out <= 1'b0;
            r_reject     <= 1'b0;
`ifdef ALARM_ESCALATE_EN
            r_trips      <= 2'd0;
            r_escalated  <= 1'b0;
`endif
        end else begin
            r_state      <= w_next;
            r_fail_cnt   <= w_fail_next;
            r_alarm      <= (w_next == ST_ALARM);
            r_unlocked   <= (w_next == ST_UNLOCKED);
            r_locked_out <= (w_next == ST_LOCKOUT);
            r_reject     <= w_reject;
`ifdef ALARM_ESCALATE_EN
            r_trips      <= w_trips_next;
            r_escalated  <= (w_next == ST_ALARM) && (w_trips_next >= 2'd2);
`endif
        end
    end

    assign bus.alarm      = r_alarm;
    assign bus.unlocked   = r_unlocked;
    assign bus.locked_out = r_locked_out;
    assign bus.reject     = r_reject;
    assign bus.fail_cnt   = r_fail_cnt;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_safe_alarm_sequencer.sv
// Self-checking bench for safe_alarm_sequencer with short timers
// (TICK_DIV=4, ALARM=3, LOCK=2, UNLOCK=5 ticks, MAX_FAILS=3).
module tb_safe_alarm_sequencer;
    import safebox_pkg::*;

    typedef struct packed {
        logic       alarm;
        logic       unlocked;
        logic       locked_out;
        logic       reject;
        logic [3:0] fail_cnt;
        logic [1:0] state;
    } obs_t;

    typedef struct {
        logic       av;
        logic       ok;
        logic       lr;
        logic       ac;
        logic [1:0] st;
        logic [3:0] fc;
        logic       rj;
    } vec_t;

    logic   clk;
    logic   rst_n;
    int     n_checks;
    int     n_errors;
    obs_t   sb[$];
    vec_t   vecs[18];

    safe_alarm_sequencer_if bus();

    safe_alarm_sequencer #(
        .MAX_FAILS    (3),
        .TICK_DIV     (4),
        .ALARM_TICKS  (3),
        .LOCK_TICKS   (2),
        .UNLOCK_TICKS (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t ex(input logic [1:0] st, input logic [3:0] fc, input logic rj);
        obs_t o;
        o.alarm      = (st == ST_ALARM);
        o.unlocked   = (st == ST_UNLOCKED);
        o.locked_out = (st == ST_LOCKOUT);
        o.reject     = rj;
        o.fail_cnt   = fc;
        o.state      = st;
        return o;
    endfunction

    function automatic obs_t sample();
        return obs_t'({bus.alarm, bus.unlocked, bus.locked_out, bus.reject,
                       bus.fail_cnt, bus.state});
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic compare_next(input string name);
        obs_t e;
        if (sb.size() == 0) begin
            check({name, " scoreboard empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(name, 32'(sample()), 32'(e));
        end
    endtask

    // Drive one set of inputs into the next edge, then compare just after it.
    task automatic cycle(input logic av, input logic ok, input logic lr, input logic ac,
                         input obs_t exp, input string name);
        bus.attempt_valid = av;
        bus.attempt_ok    = ok;
        bus.lock_req      = lr;
        bus.admin_clear   = ac;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        compare_next(name);
    endtask

    task automatic hold(input int n, input logic [1:0] st, input logic [3:0] fc,
                        input string name);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 1'b0, 1'b0, 1'b0, ex(st, fc, 1'b0), $sformatf("%s_%0d", name, i));
    endtask

    task automatic three_fails(input string name);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, ex(ST_IDLE,  4'd1, 1'b0), {name, "_f1"});
        cycle(1'b1, 1'b0, 1'b0, 1'b0, ex(ST_IDLE,  4'd2, 1'b0), {name, "_f2"});
        cycle(1'b1, 1'b0, 1'b0, 1'b0, ex(ST_ALARM, 4'd3, 1'b0), {name, "_f3"});
    endtask

    task automatic async_reset_check(input string name);
        #3;
        rst_n = 1'b0;
        #1;
        sb.push_back(ex(ST_IDLE, 4'd0, 1'b0));
        compare_next(name);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.attempt_valid = 1'b0;
        bus.attempt_ok    = 1'b0;
        bus.lock_req      = 1'b0;
        bus.admin_clear   = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE,     4'd1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE,     4'd2, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, ST_UNLOCKED, 4'd0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, ST_UNLOCKED, 4'd0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, ST_UNLOCKED, 4'd0, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, ST_UNLOCKED, 4'd0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST_IDLE,     4'd0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE,     4'd1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, ST_IDLE,     4'd1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, ST_IDLE,     4'd1, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, ST_UNLOCKED, 4'd0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, ST_IDLE,     4'd0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE,     4'd1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, ST_IDLE,     4'd0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE,     4'd1, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, ST_IDLE,     4'd2, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b1, ST_IDLE,     4'd0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE,     4'd0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        sb.push_back(ex(ST_IDLE, 4'd0, 1'b0));
        compare_next("reset");
        rst_n = 1'b1;

        // Correct attempt, then auto-relock exactly 20 cycles after entry.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, ex(ST_UNLOCKED, 4'd0, 1'b0), "unlock");
        for (int i = 1; i <= 20; i++)
            cycle(1'b0, 1'b0, 1'b0, 1'b0,
                  ex((i < 20) ? ST_UNLOCKED : ST_IDLE, 4'd0, 1'b0),
                  $sformatf("unlock_win_%0d", i));

        for (int i = 0; i < 18; i++)
            cycle(vecs[i].av, vecs[i].ok, vecs[i].lr, vecs[i].ac,
                  ex(vecs[i].st, vecs[i].fc, vecs[i].rj), $sformatf("vec%0d", i));

        // lock_req on the expiry edge gives a single transition to IDLE.
        cycle(1'b1, 1'b1, 1'b0, 1'b0, ex(ST_UNLOCKED, 4'd0, 1'b0), "lr_exp_entry");
        hold(19, ST_UNLOCKED, 4'd0, "lr_exp_win");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, ex(ST_IDLE, 4'd0, 1'b0), "lr_exp_edge");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, ex(ST_IDLE, 4'd0, 1'b0), "lr_exp_after");

        // Alarm 12 cycles, lockout 8, attempts rejected without stretching either.
        three_fails("trip1");
`ifdef ALARM_ESCALATE_EN
        check("trip1_escalated", 32'(bus.escalated), 32'd0);
`endif
        for (int i = 1; i <= 12; i++) begin
            logic av;
            av = (i == 1) || (i == 3) || (i == 12);
            cycle(av, (i == 3), 1'b0, 1'b0,
                  ex((i < 12) ? ST_ALARM : ST_LOCKOUT, 4'd3, av),
                  $sformatf("alarm_%0d", i));
        end
        for (int i = 1; i <= 8; i++) begin
            logic av;
            av = (i == 1) || (i == 8);
            cycle(av, 1'b0, 1'b0, 1'b0,
                  ex((i < 8) ? ST_LOCKOUT : ST_IDLE, (i < 8) ? 4'd3 : 4'd0, av),
                  $sformatf("lockout_%0d", i));
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, ex(ST_IDLE, 4'd0, 1'b0), "post_lockout");

        // admin_clear mid-ALARM together with an attempt.
        three_fails("trip2");
`ifdef ALARM_ESCALATE_EN
        check("trip2_escalated", 32'(bus.escalated), 32'd1);
        hold(110, ST_ALARM, 4'd3, "escalated_hold");
        check("escalated_still", 32'(bus.escalated), 32'd1);
`else
        hold(5, ST_ALARM, 4'd3, "alarm_mid");
`endif
        cycle(1'b1, 1'b0, 1'b0, 1'b1, ex(ST_IDLE, 4'd0, 1'b0), "admin_clear");
`ifdef ALARM_ESCALATE_EN
        check("admin_escalated", 32'(bus.escalated), 32'd0);
`endif
        cycle(1'b0, 1'b0, 1'b0, 1'b0, ex(ST_IDLE, 4'd0, 1'b0), "post_admin");

        // Asynchronous reset mid-LOCKOUT, then mid-ALARM.
        three_fails("trip3");
        hold(11, ST_ALARM, 4'd3, "trip3_alarm");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, ex(ST_LOCKOUT, 4'd3, 1'b0), "trip3_lock");
        hold(3, ST_LOCKOUT, 4'd3, "trip3_lockhold");
        async_reset_check("rst_mid_lockout");

        three_fails("trip4");
        hold(2, ST_ALARM, 4'd3, "trip4_alarm");
        async_reset_check("rst_mid_alarm");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, ex(ST_IDLE, 4'd1, 1'b0), "post_reset_fail");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
